fft_frame_arbiter: RTL and testbench

FFT_FRAME_ARBITER -- requirements
Module: fft_frame_arbiter

---
 rtl/fft_pkg.sv | 12 +
 rtl/fft_tag_fifo.sv | 58 +++++
 rtl/fft_frame_arbiter.sv | 143 ++++++++++++++
 tb/tb_fft_frame_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and arbiter state encoding for the FFT frame arbiter slice.
package fft_pkg;

    localparam int SIGNAL_W = 50;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fft_tag_fifo.sv
// One-bit-wide tag FIFO recording which channel owns each frame inside the FFT core.
module fft_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic push_data_i,
    input  logic pop_i,
    output logic head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop_i && !push_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= ptr_next(wr_q);
            if (pop_i)  rd_q <= ptr_next(rd_q);
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fft_frame_arbiter.sv
// Two-channel frame arbiter in front of an FFT core; tags each frame with its
// source channel and re-attaches that tag to the core's results.
module fft_frame_arbiter
    import fft_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int TAG_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [SIGNAL_W-1:0] ch0_signal_i,
    input  logic                ch0_valid_i,
    output logic                ch0_ready_o,
    input  logic [SIGNAL_W-1:0] ch1_signal_i,
    input  logic                ch1_valid_i,
    output logic                ch1_ready_o,
    output logic [SIGNAL_W-1:0] core_signal_o,
    output logic                core_valid_o,
    input  logic                core_ready_i,
    input  logic [SIGNAL_W-1:0] core_signal_i,
    input  logic                core_valid_i,
    output logic                core_ready_o,
    output logic [SIGNAL_W-1:0] out_signal_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                out_chan_o,
    output logic                out_last_o,
    output logic                err_o,
    output arb_state_e          dbg_state_o
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

    arb_state_e       state_q;
    logic             ptr_q;
    logic [CNT_W-1:0] in_cnt_q;
    logic [CNT_W-1:0] out_cnt_q;
    logic             err_q;

    logic tag_full;
    logic tag_empty;
    logic tag_head;
    logic in_fire;
    logic out_fire;
    logic tag_push;
    logic tag_pop;

    // Valid/ready: a beat moves on a pair exactly in a cycle where both are high.
    always_comb begin
        core_signal_o = '0;
        core_valid_o  = 1'b0;
        ch0_ready_o   = 1'b0;
        ch1_ready_o   = 1'b0;
        case (state_q)
            GRANT0: begin
                core_signal_o = ch0_signal_i;
                core_valid_o  = ch0_valid_i;
                ch0_ready_o   = core_ready_i;
            end
            GRANT1: begin
                core_signal_o = ch1_signal_i;
                core_valid_o  = ch1_valid_i;
                ch1_ready_o   = core_ready_i;
            end
            default: ;
        endcase
    end

    assign in_fire  = core_valid_o & core_ready_i;
    assign tag_push = in_fire & (in_cnt_q == LAST_BEAT);

    // Results are held off while no tag is outstanding, so none is ever lost.
    assign out_signal_o = core_signal_i;
    assign out_valid_o  = core_valid_i & ~tag_empty;
    assign core_ready_o = out_ready_i & ~tag_empty;
    assign out_fire     = core_valid_i & core_ready_o;
    assign tag_pop      = out_fire & (out_cnt_q == LAST_BEAT);
    assign out_chan_o   = tag_head & ~tag_empty;
    assign out_last_o   = (out_cnt_q == LAST_BEAT);
    assign err_o        = err_q;
    assign dbg_state_o  = state_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            in_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!tag_full && (ch0_valid_i || ch1_valid_i)) begin
                        if (ch0_valid_i && ch1_valid_i) begin
                            state_q <= ptr_q ? GRANT1 : GRANT0;
                        end else begin
                            state_q <= ch0_valid_i ? GRANT0 : GRANT1;
                        end
                    end
                end
                GRANT0, GRANT1: begin
                    if (in_fire) begin
                        if (in_cnt_q == LAST_BEAT) begin
                            in_cnt_q <= '0;
                            ptr_q    <= (state_q == GRANT0);
                            state_q  <= IDLE;
                        end else begin
                            in_cnt_q <= in_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            out_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (out_fire) begin
                out_cnt_q <= (out_cnt_q == LAST_BEAT) ? '0 : out_cnt_q + 1'b1;
            end
            if (core_valid_i && tag_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    fft_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (tag_push),
        .push_data_i (state_q == GRANT1),
        .pop_i       (tag_pop),
        .head_o      (tag_head),
        .full_o      (tag_full),
        .empty_o     (tag_empty)
    );

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Randomised and directed bench for fft_frame_arbiter against a frame-level model.
module tb_fft_frame_arbiter;
  import fft_pkg::*;

  localparam int FL = 8;
  localparam int TD = 4;
  localparam logic [49:0] XK = 50'h1_2345_6789_ABCD;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_i = 1'b0;

  logic [49:0] ch0_signal_i = '0, ch1_signal_i = '0, core_signal_i = '0;
  logic ch0_valid_i = 0, ch1_valid_i = 0, core_ready_i = 0, core_valid_i = 0, out_ready_i = 0;
  logic ch0_ready_o, ch1_ready_o, core_valid_o, core_ready_o, out_valid_o, out_chan_o, out_last_o, err_o;
  logic [49:0] core_signal_o, out_signal_o;
  arb_state_e dbg_state_o;

  fft_frame_arbiter #(.FRAME_LEN(FL), .TAG_DEPTH(TD)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ch0_signal_i(ch0_signal_i), .ch0_valid_i(ch0_valid_i), .ch0_ready_o(ch0_ready_o),
    .ch1_signal_i(ch1_signal_i), .ch1_valid_i(ch1_valid_i), .ch1_ready_o(ch1_ready_o),
    .core_signal_o(core_signal_o), .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
    .core_signal_i(core_signal_i), .core_valid_i(core_valid_i), .core_ready_o(core_ready_o),
    .out_signal_o(out_signal_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_chan_o(out_chan_o), .out_last_o(out_last_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  int checks = 0;
  int failures = 0;

  // frame-level model: owner of the input path (-1 = none), tags in flight
  int m_owner = -1, m_beats = 0, m_ptr = 0, m_outb = 0;
  bit m_err = 0;
  int m_tags[$];
  bit chk_en = 0;

  // scoreboard and FFT core emulator (identity transform XOR XK, whole frames only)
  logic [49:0] exp_q[$];
  int exp_ch_q[$];
  logic [49:0] core_q[$];
  int core_acc = 0, ready_beats = 0;

  int grant_log[$];
  int out_chan_log[$];
  int frames_in = 0, out_xfers = 0, last_cnt = 0;
  arb_state_e prev_state = IDLE;

  // stimulus modes: 0 off, 1 on, 2 random, 3 toggle
  int m0 = 0, m1 = 0, cr_mode = 1, or_mode = 1;
  bit core_rand = 0, inject = 0, tog = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [49:0] rnd50();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[49:0];
  endfunction

  // compare process: check outputs against the model, then advance the model
  initial begin
    forever begin
      @(negedge clk);
      begin
        bit v[2];
        logic [49:0] s[2];
        bit nonempty, full_now, in_fire, out_fire, exp_cv;
        arb_state_e exp_st;
        v[0] = ch0_valid_i; v[1] = ch1_valid_i;
        s[0] = ch0_signal_i; s[1] = ch1_signal_i;
        nonempty = (m_tags.size() > 0);
        full_now = (m_tags.size() >= TD);
        exp_cv = (m_owner >= 0) && v[m_owner];
        if (chk_en) begin
          exp_st = (m_owner < 0) ? IDLE : ((m_owner == 0) ? GRANT0 : GRANT1);
          check("state", 64'(dbg_state_o), 64'(exp_st));
          check("ch0_ready", 64'(ch0_ready_o), 64'((m_owner == 0) && core_ready_i));
          check("ch1_ready", 64'(ch1_ready_o), 64'((m_owner == 1) && core_ready_i));
          check("core_valid", 64'(core_valid_o), 64'(exp_cv));
          if (exp_cv) check("core_signal", 64'(core_signal_o), 64'(s[m_owner]));
          check("core_ready_o", 64'(core_ready_o), 64'(out_ready_i && nonempty));
          check("out_valid", 64'(out_valid_o), 64'(core_valid_i && nonempty));
          if (out_valid_o) check("out_signal", 64'(out_signal_o), 64'(core_signal_i));
          if (nonempty) check("out_chan", 64'(out_chan_o), 64'(m_tags[0]));
          check("out_last", 64'(out_last_o), 64'(m_outb == FL - 1));
          check("err", 64'(err_o), 64'(m_err));
        end
        if (!rst_i) begin
          m_owner = -1; m_beats = 0; m_ptr = 0; m_outb = 0; m_err = 0;
          m_tags.delete(); exp_q.delete(); exp_ch_q.delete(); core_q.delete();
          core_acc = 0; ready_beats = 0; grant_log.delete(); out_chan_log.delete();
          frames_in = 0; out_xfers = 0; last_cnt = 0; prev_state = IDLE;
          chk_en = 1;
        end else if (chk_en) begin
          if (prev_state == IDLE && dbg_state_o != IDLE) grant_log.push_back(dbg_state_o == GRANT1 ? 1 : 0);
          prev_state = dbg_state_o;
          in_fire = exp_cv && core_ready_i;
          out_fire = core_valid_i && out_ready_i && nonempty;
          if (core_valid_i && !nonempty) m_err = 1;
          if (in_fire) begin
            exp_q.push_back(s[m_owner] ^ XK);
            exp_ch_q.push_back(m_owner);
            core_q.push_back(s[m_owner] ^ XK);
            core_acc++;
            if (core_acc == FL) begin ready_beats += FL; core_acc = 0; end
          end
          if (out_fire) begin
            if (exp_q.size() == 0) begin
              check("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
              if (m_outb == 0) out_chan_log.push_back(out_chan_o);
              check("sb_data", 64'(out_signal_o), 64'(exp_q.pop_front()));
              check("sb_chan", 64'(out_chan_o), 64'(exp_ch_q.pop_front()));
              void'(core_q.pop_front());
              ready_beats--;
            end
            out_xfers++;
            if (out_last_o) last_cnt++;
            m_outb++;
            if (m_outb == FL) begin m_outb = 0; void'(m_tags.pop_front()); end
          end
          if (m_owner < 0) begin
            if (!full_now && (v[0] || v[1])) m_owner = (v[0] && v[1]) ? m_ptr : (v[0] ? 0 : 1);
          end else if (in_fire) begin
            m_beats++;
            if (m_beats == FL) begin
              m_beats = 0; m_tags.push_back(m_owner); frames_in++;
              m_ptr = 1 - m_owner; m_owner = -1;
            end
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel(input int mode);
    case (mode)
      1: return 1'b1;
      2: return 1'($urandom_range(0, 1));
      3: return tog;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive();
    tog = ~tog;
    ch0_valid_i = sel(m0);
    ch1_valid_i = sel(m1);
    ch0_signal_i = rnd50();
    ch1_signal_i = rnd50();
    core_ready_i = (cr_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    out_ready_i = sel(or_mode);
    if (inject) begin
      core_valid_i = 1'b1; core_signal_i = rnd50();
    end else if (ready_beats > 0) begin
      core_valid_i = core_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      core_signal_i = core_q[0];
    end else begin
      core_valid_i = 1'b0; core_signal_i = rnd50();
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin tick(); drive(); end
  endtask

  // which: 0 frames_in, 1 out_xfers, 2 grants, 3 ch1 beats accepted
  task automatic wait_ge(input string name, input int which, input int target, input int budget);
    int val;
    for (int i = 0; i < budget; i++) begin
      tick();
      case (which)
        0: val = frames_in;
        1: val = out_xfers;
        2: val = grant_log.size();
        default: val = (m_owner == 1) ? m_beats : 0;
      endcase
      if (val >= target) return;
      drive();
    end
    checks++; failures++;
    $display("FAIL timeout_%s actual=%0d required=%0d", name, val, target);
  endtask

  task automatic do_reset();
    rst_i = 1'b0; m0 = 0; m1 = 0; inject = 0; core_rand = 0; cr_mode = 1; or_mode = 1;
    run(2);
    rst_i = 1'b1;
    drive();
  endtask

  initial begin
    do_reset();
    tick();
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_state", 64'(dbg_state_o), 64'(IDLE));

    // single ch0 frame
    m0 = 1; drive();
    wait_ge("a_in", 0, 1, 40);
    m0 = 0; drive();
    wait_ge("a_out", 1, 8, 40);
    check("a_out_cnt", 64'(out_xfers), 64'd8);
    check("a_last_cnt", 64'(last_cnt), 64'd1);
    check("a_grants", 64'(grant_log.size()), 64'd1);
    check("a_chan", 64'(out_chan_log[0]), 64'd0);

    // both channels continuous, 4 frames
    do_reset();
    m0 = 1; m1 = 1; drive();
    wait_ge("b_in", 0, 4, 80);
    m0 = 0; m1 = 0; drive();
    wait_ge("b_out", 1, 32, 60);
    check("b_grant_cnt", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));
      check($sformatf("b_outchan%0d", i), 64'(out_chan_log[i]), 64'(i % 2));
    end

    // output stalled until the tag FIFO fills
    do_reset();
    or_mode = 0; m0 = 1; m1 = 1; drive();
    wait_ge("c_fill", 0, 4, 80);
    drive();
    run(20);
    check("c_no_5th", 64'(grant_log.size()), 64'd4);
    check("c_state", 64'(dbg_state_o), 64'(IDLE));
    check("c_rdy0", 64'(ch0_ready_o), 64'd0);
    check("c_rdy1", 64'(ch1_ready_o), 64'd0);
    or_mode = 1; drive();
    wait_ge("c_5th", 2, 5, 40);
    check("c_5th_ch", 64'(grant_log[4]), 64'd0);
    drive();
    wait_ge("c_in5", 0, 5, 40);
    m0 = 0; m1 = 0; drive();
    wait_ge("c_drain", 1, 40, 120);

    // ch0 toggling valid while ch1 always valid
    do_reset();
    tog = 0; m0 = 3; m1 = 1; drive();
    wait_ge("d_in", 0, 1, 60);
    m0 = 0; m1 = 0; drive();
    check("d_grants", 64'(grant_log.size()), 64'd1);
    check("d_grant0", 64'(grant_log[0]), 64'd0);
    wait_ge("d_out", 1, 8, 40);

    // result with no tag outstanding
    drive();
    inject = 1; drive();
    run(3);
    check("e_err", 64'(err_o), 64'd1);
    check("e_core_ready", 64'(core_ready_o), 64'd0);
    inject = 0; drive();
    run(5);
    check("e_err_sticky", 64'(err_o), 64'd1);

    // reset in the middle of a ch1 frame
    do_reset();
    m1 = 1; drive();
    wait_ge("f_beats", 3, 3, 40);
    rst_i = 1'b0;
    tick();
    check("f_rdy0", 64'(ch0_ready_o), 64'd0);
    check("f_rdy1", 64'(ch1_ready_o), 64'd0);
    check("f_core_valid", 64'(core_valid_o), 64'd0);
    check("f_out_valid", 64'(out_valid_o), 64'd0);
    check("f_core_ready", 64'(core_ready_o), 64'd0);
    rst_i = 1'b1; m0 = 1; m1 = 1; drive();
    wait_ge("f_grant", 2, 1, 20);
    check("f_grant0", 64'(grant_log[0]), 64'd0);
    drive();

    // randomised traffic with rare resets
    m0 = 2; m1 = 2; cr_mode = 2; or_mode = 2; core_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst_i = ($urandom_range(0, 999) != 0);
      drive();
    end
    rst_i = 1'b1;
    run(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
